// File: rtl/cordic_result_collector.sv
// -----------------------------------------------------------------------------
// cordic_result_collector
//
// Sits behind cordic_wrapper. The CORDIC output cannot be stalled, so every
// valid word is captured into a DEPTH-entry first-word-fall-through FIFO. A
// consumer drains that FIFO over a valid/ready handshake. A word that arrives
// while the FIFO is full, with no pop in the same cycle, is dropped and sets a
// sticky overflow flag.
//
// Optional build macro:
//   CORDIC_COLLECT_STATS_EN - when defined, adds saturating accepted-word and
//                             dropped-word counters. When undefined, both
//                             counter outputs are tied to zero.
//
// Ports:
//   i_clk        clock; all state changes on its rising edge
//   i_async_rst  asynchronous active-low reset; clears all state and memory
//   i_en         capture enable (gates push and drop, never pop)
//   i_clr        synchronous flush; wins over push and pop
//   i_vld/i_data incoming CORDIC word; low OUTPUT_DATA_WIDTH bits are stored
//   o_vld/o_data FIFO head (FWFT), o_vld = !o_empty
//   i_rdy        consumer ready
//   o_level      occupancy 0..DEPTH
//   o_full       o_level == DEPTH
//   o_empty      o_level == 0
//   o_ovf        sticky overflow flag
//   o_word_cnt   accepted-word count (stats build only, else 0)
//   o_drop_cnt   dropped-word count (stats build only, else 0)
// -----------------------------------------------------------------------------
module cordic_result_collector #(
  parameter int DATA_WIDTH        = 56,
  parameter int OUTPUT_DATA_WIDTH = 54,
  parameter int DEPTH             = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         i_clk,
  input  logic                         i_async_rst,
  input  logic                         i_en,
  input  logic                         i_clr,
  input  logic                         i_vld,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_vld,
  output logic [OUTPUT_DATA_WIDTH-1:0] o_data,
  input  logic                         i_rdy,
  output logic [$clog2(DEPTH):0]       o_level,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_ovf,
  output logic [CNT_WIDTH-1:0]         o_word_cnt,
  output logic [CNT_WIDTH-1:0]         o_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [OUTPUT_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [OUTPUT_DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]             level_q, level_d;
  logic                         ovf_q, ovf_d;

  logic push, pop, drop;

  // Upper CORDIC bits are intentionally discarded.
  generate
    if (DATA_WIDTH > OUTPUT_DATA_WIDTH) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^i_data[DATA_WIDTH-1:OUTPUT_DATA_WIDTH];
    end
  endgenerate

  // Flags come straight from the level register; the head word is a
  // combinational read so a freshly pushed word is visible after one edge.
  assign o_level = level_q;
  assign o_full  = (level_q == LVL_FULL);
  assign o_empty = (level_q == '0);
  assign o_vld   = !o_empty;
  assign o_data  = mem_q[rd_ptr_q];
  assign o_ovf   = ovf_q;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop  = o_vld & i_rdy;
  assign push = i_en & i_vld & (!o_full | pop);
  assign drop = i_en & i_vld & o_full & !pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (i_clr) begin
      // Flush leaves memory contents alone; only the bookkeeping is reset.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = i_data[OUTPUT_DATA_WIDTH-1:0];
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_async_rst) begin
    if (!i_async_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef CORDIC_COLLECT_STATS_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    word_cnt_d = word_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (i_clr) begin
      word_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (push) word_cnt_d = sat_inc(word_cnt_q);
      if (drop) drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_async_rst) begin
    if (!i_async_rst) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_word_cnt = word_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_word_cnt = '0;
  assign o_drop_cnt = '0;
`endif

endmodule
